// File: rtl/conv_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : conv_group_scheduler
// Purpose  : Steps K filters through NUM_PAR engines one group at a time and
//            hands each group's results to the output buffer via ready/valid.
// Revision : 1.0 - initial release
// ============================================================================
module conv_group_scheduler #(
  parameter int K             = 6,
  parameter int NUM_PAR       = 2,
  parameter int ENGINE_CYCLES = 10,
  parameter int GROUP_W       = 8,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
  output logic               engine_rst,
  output logic               engine_en,
  output logic [GROUP_W-1:0] filter_group,
  output logic               out_valid,
  output logic [GROUP_W-1:0] out_group,
  output logic [NUM_PAR-1:0] lane_valid,
  output logic               busy,
  output logic               done
);

  localparam int                 c_NUM_GROUPS = (K + NUM_PAR - 1) / NUM_PAR;
  localparam int                 c_LAST_LANES = K - (c_NUM_GROUPS - 1) * NUM_PAR;
  localparam logic [GROUP_W-1:0] c_LAST_GROUP = GROUP_W'(c_NUM_GROUPS - 1);
  localparam logic [CNT_W-1:0]   c_CNT_LAST   = CNT_W'(ENGINE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [GROUP_W-1:0] r_group;
  logic [NUM_PAR-1:0] r_lane_valid;
  logic               r_engine_rst;
  logic               r_engine_en;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;

  logic [NUM_PAR-1:0] w_last_mask;
  logic [NUM_PAR-1:0] w_idle_lanes;
  logic [NUM_PAR-1:0] w_inc_lanes;
  logic [GROUP_W-1:0] w_group_inc;
  logic               w_to_idle;

  for (genvar i = 0; i < NUM_PAR; i++) begin : g_last_mask
    assign w_last_mask[i] = (i < c_LAST_LANES);
  end

  assign w_idle_lanes = (c_NUM_GROUPS == 1) ? w_last_mask : {NUM_PAR{1'b1}};
  assign w_group_inc  = r_group + GROUP_W'(1);
  assign w_inc_lanes  = (w_group_inc == c_LAST_GROUP) ? w_last_mask : {NUM_PAR{1'b1}};

  // Reset, an abort of an active pass and the DONE cycle all land in the same IDLE state.
  assign w_to_idle = reset || (abort && (r_state != S_IDLE)) || (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (w_to_idle) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_group      <= '0;
      r_lane_valid <= w_idle_lanes;
      r_engine_rst <= 1'b1;
      r_engine_en  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state      <= S_RUN;
          r_cnt        <= '0;
          r_engine_rst <= 1'b0;
          r_engine_en  <= 1'b1;
        end
        S_RUN: begin
          if (r_cnt == c_CNT_LAST) begin
            r_state     <= S_CAPTURE;
            r_cnt       <= '0;
            r_engine_en <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          // Engines stay frozen until the buffer takes this group.
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_engine_rst <= 1'b1;
            if (r_group == c_LAST_GROUP) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_LOAD;
              r_group      <= w_group_inc;
              r_lane_valid <= w_inc_lanes;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign engine_rst   = r_engine_rst;
  assign engine_en    = r_engine_en;
  assign filter_group = r_group;
  assign out_valid    = r_out_valid;
  assign out_group    = r_group;
  assign lane_valid   = r_lane_valid;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
`default_nettype wire
